pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, registered two-operand adder/subtractor for the arithmetic benchmark set; successor to the fixed-width registered adder.
- Width is a parameter. The carry chain is split into STAGES pipeline segments to trade latency for clock rate.
- Supports add and subtract modes per transaction, plus valid/ready flow control with backpressure.
- Drops into benchmark tops wherever a registered a+b with carry-out is needed.

Parameters:
- WIDTH, 19, operand width in bits; must be >= 1.
- STAGES, 1, number of carry-segment pipeline stages; 1 <= STAGES <= WIDTH.
- SEG, derived = ceil(WIDTH/STAGES), bits per segment; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  operand A, unsigned
- in_b  input  WIDTH  operand B, unsigned
- in_sub  input  1  0: A+B; 1: A-B
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH+1  result; MSB is carry-out

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst is high: out_valid=0, out_sum=0, and all stage valids, operand registers and carry registers are 0.
  - in_ready=1 (combinational from out_valid).
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a rising clk.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline structure:
  - Stage 0 captures in_a, in_b and in_sub. In subtract mode, stage 0 stores ~in_b and sets the carry-in to 1; in add mode the carry-in is 0.
  - Stage k (1..STAGES) adds bits [min((k-1)*SEG,WIDTH) .. min(k*SEG,WIDTH)-1] with the carry from stage k-1.
  - Each stage registers its partial sum, its carry, and the remaining operand bits.
  - An empty segment (possible when SEG*(STAGES-1) >= WIDTH) passes its carry and data through unchanged.
  - Stage STAGES is the output register: out_sum[WIDTH] = final carry.
- Latency is exactly STAGES+1 cycles from input transfer to out_valid, when there is no stall. STAGES=1 gives 2 cycles (input register, then sum register).
- Throughput is one transaction per cycle.
- Arithmetic:
  - Add mode: out_sum = in_a + in_b, a full (WIDTH+1)-bit result with no truncation.
  - Subtract mode: out_sum = in_a + ~in_b + 1, computed in WIDTH+1 bits. out_sum[WIDTH]=1 iff in_a >= in_b (no borrow); the low WIDTH bits are the two's-complement difference mod 2^WIDTH.
- Flow control:
  - advance = !out_valid | out_ready. All stages shift together when advance=1 and all hold when advance=0.
  - in_ready = advance (combinational; no path from in_valid to in_ready).
  - Bubbles (invalid stages) still shift when advance=1. A stage whose valid bit is 0 holds don't-care data, but out_sum keeps its last value when out_valid=0 after reset.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both accepted; the pipeline shifts.
  - A stall longer than STAGES+1 cycles loses no data and preserves order.
- Reset mid-operation:
  - All in-flight transactions are discarded.
  - out_valid drops asynchronously with rst, not waiting for clk.
  - The first input transfer is accepted on the first rising clk after rst deasserts.
- in_sub is sampled only on input transfer. Changing in_sub between transfers has no effect on in-flight results.

Decomposition:
- Package pipelined_adder_pkg:
  - Function seg_lo(k, WIDTH, STAGES), the clamped segment start bit.
  - Function seg_w(k, WIDTH, STAGES), the clamped segment width, which may be 0.
  - Constant for ceil division.
- One sub-module, adder_pipe_stage, instantiated STAGES times via generate.
  - Parameters: segment lo/width.
  - Responsibilities: registered segment add, carry register, operand pass-through, valid bit, enable = advance, asynchronous clear on rst.
- Top-level responsibilities: stage 0 capture/inversion, advance/in_ready logic, output mapping.

Test Plan:
1. Reset: assert rst mid-clock with WIDTH=19, STAGES=3 -> out_valid=0, out_sum=20'h0, in_ready=1 immediately, without waiting for a clock edge.
2. Full carry ripple: WIDTH=19, STAGES=3, add 19'h7FFFF+19'h00001 -> out_sum=20'h80000 with out_valid high exactly 4 cycles after transfer; the carry crosses segments 0-6, 7-13 and 14-18.
3. Subtract: 5-7 -> out_sum=20'h7FFFE (MSB=0, borrow); 10-3 -> 20'h80007 (MSB=1); 0-0 -> 20'h80000.
4. Backpressure: stream 8 random add/sub transactions back-to-back and hold out_ready=0 for 5 cycles mid-stream.
   - in_ready is low throughout the stall.
   - All 8 results emerge in order and match the reference model; none are dropped or duplicated.
5. Reset mid-stream: 3 transactions in flight, then pulse rst for 1 cycle -> no stale result ever appears. A new transaction 19'h00010+19'h00020 issued after reset yields 20'h00030 after 4 cycles.
6. Degenerate configs:
   - WIDTH=19, STAGES=1: latency 2; 19'h40000+19'h40000 -> 20'h80000.
   - WIDTH=10, STAGES=6 (empty last segment): 10'h3FF+10'h001 -> 11'h400 with latency 7.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared types and segment-geometry helpers for pipelined_adder
package pipelined_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Segment k (1-based) covers [seg_lo, seg_lo+seg_w); trailing segments may be empty.
  function automatic int seg_lo(input int k, input int width, input int stages);
    int lo;
    lo = (k - 1) * ceil_div(width, stages);
    return (lo < width) ? lo : width;
  endfunction

  function automatic int seg_w(input int k, input int width, input int stages);
    int hi;
    hi = k * ceil_div(width, stages);
    if (hi > width) hi = width;
    return hi - seg_lo(k, width, stages);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one carry segment: adds bits [LO +: SW] and registers the partial result
module adder_pipe_stage #(
  parameter int WIDTH = 19,
  parameter int LO    = 0,
  parameter int SW    = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] nxt_sum;
  logic             nxt_carry;

  if (SW > 0) begin : g_add
    logic [SW:0] part;
    assign part = {1'b0, prev_a[LO +: SW]} + {1'b0, prev_b[LO +: SW]} + {{SW{1'b0}}, prev_carry};
    always_comb begin
      nxt_sum = prev_sum;
      nxt_sum[LO +: SW] = part[SW-1:0];
    end
    assign nxt_carry = part[SW];
  end else begin : g_empty
    assign nxt_sum   = prev_sum;
    assign nxt_carry = prev_carry;
  end

  // Data only loads behind a valid beat so the output keeps its last result across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a     <= prev_a;
        b     <= prev_b;
        sum   <= nxt_sum;
        carry <= nxt_carry;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - registered add/subtract with a STAGES-segment carry pipeline and valid/ready flow control
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 19,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  logic             advance;
  op_e              op;
  logic             v0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             c0;

  logic             v_q [STAGES+1];
  logic [WIDTH-1:0] a_q [STAGES+1];
  logic [WIDTH-1:0] b_q [STAGES+1];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic             c_q [STAGES+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign op       = op_e'(in_sub);

  // Subtraction is A + ~B + 1: invert B here and seed the carry chain with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
      c0 <= 1'b0;
    end else if (advance) begin
      v0 <= in_valid;
      if (in_valid) begin
        a0 <= in_a;
        b0 <= (op == OP_SUB) ? ~in_b : in_b;
        c0 <= (op == OP_SUB);
      end
    end
  end

  assign v_q[0] = v0;
  assign a_q[0] = a0;
  assign b_q[0] = b0;
  assign s_q[0] = '0;
  assign c_q[0] = c0;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .LO    (seg_lo(k, WIDTH, STAGES)),
      .SW    (seg_w(k, WIDTH, STAGES))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (advance),
      .prev_valid (v_q[k-1]),
      .prev_a     (a_q[k-1]),
      .prev_b     (b_q[k-1]),
      .prev_sum   (s_q[k-1]),
      .prev_carry (c_q[k-1]),
      .valid      (v_q[k]),
      .a          (a_q[k]),
      .b          (b_q[k]),
      .sum        (s_q[k]),
      .carry      (c_q[k])
    );
  end

  logic unused_ops;
  assign unused_ops = ^{a_q[STAGES], b_q[STAGES]};

  assign out_valid = v_q[STAGES];
  assign out_sum   = {c_q[STAGES], s_q[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder in 19/3, 19/1 and 10/6 configurations
module tb_pipelined_adder;

  typedef struct {
    logic [19:0] sum;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  v;
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic        or_s;
  logic [18:0] in_a;
  logic [18:0] in_b;
  logic        in_sub;
  logic [19:0] s0;
  logic [19:0] s1;
  logic [10:0] s2;
  logic [19:0] sum_d [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sum_d[0] = s0;
  assign sum_d[1] = s1;
  assign sum_d[2] = {9'd0, s2};

  pipelined_adder #(.WIDTH(19), .STAGES(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov[0]), .out_ready(or_s), .out_sum(s0));
  pipelined_adder #(.WIDTH(19), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov[1]), .out_ready(or_s), .out_sum(s1));
  pipelined_adder #(.WIDTH(10), .STAGES(6)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(rdy[2]), .in_a(in_a[9:0]), .in_b(in_b[9:0]),
    .in_sub(in_sub), .out_valid(ov[2]), .out_ready(or_s), .out_sum(s2));

  function automatic int st(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 1 : 6);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents operands now (inputs already aligned just after a rising edge) and records the expectation.
  task automatic issue(input int d, input logic [18:0] a, input logic [18:0] b, input logic sub,
                       input logic [19:0] exp, input bit lat);
    int   guard;
    exp_t e;
    in_a = a; in_b = b; in_sub = sub;
    v = '0; v[d] = 1'b1;
    #1;
    guard = 0;
    while (!rdy[d] && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!rdy[d]) check("issue_ready_timeout", {31'd0, rdy[d]}, 32'd1);
    e.sum = exp;
    e.cyc = lat ? cyc + 1 + st(d) : -1;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic send(input int d, input logic [18:0] a, input logic [18:0] b, input logic sub,
                      input logic [19:0] exp, input bit lat);
    @(posedge clk); #1;
    issue(d, a, b, sub, exp, lat);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    v = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && or_s) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          exp_t e;
          bit   have;
          have = 1'b0;
          case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got %h expected no output", d, sum_d[d]);
          end else begin
            check($sformatf("sum_dut%0d", d), {12'd0, sum_d[d]}, {12'd0, e.sum});
            if (e.cyc >= 0) check($sformatf("latency_dut%0d", d), cyc, e.cyc);
          end
        end
      end
    end
  end

  logic [18:0] bp_a   [8] = '{19'h12345, 19'h7FFFF, 19'h00100, 19'h40000,
                              19'h55555, 19'h3FFFF, 19'h7FFFF, 19'h00001};
  logic [18:0] bp_b   [8] = '{19'h00FFF, 19'h7FFFF, 19'h00200, 19'h40000,
                              19'h2AAAA, 19'h00001, 19'h7FFFF, 19'h00002};
  logic        bp_sub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [19:0] bp_exp [8] = '{20'h13344, 20'h80000, 20'h7FF00, 20'h80000,
                              20'h7FFFF, 20'hBFFFE, 20'hFFFFE, 20'h7FFFF};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v = '0; or_s = 1'b1; in_a = '0; in_b = '0; in_sub = 1'b0;
    @(posedge clk); #1;
    check("reset_out_valid", {29'd0, ov}, 32'd0);
    check("reset_sum0", {12'd0, s0}, 32'd0);
    check("reset_sum2", {21'd0, s2}, 32'd0);
    check("reset_in_ready", {29'd0, rdy}, 32'h7);
    rst = 1'b0;

    send(0, 19'h7FFFF, 19'h00001, 1'b0, 20'h80000, 1'b1);
    send(0, 19'h00005, 19'h00007, 1'b1, 20'h7FFFE, 1'b1);
    send(0, 19'h0000A, 19'h00003, 1'b1, 20'h80007, 1'b1);
    send(0, 19'h00000, 19'h00000, 1'b1, 20'h80000, 1'b1);
    idle();
    repeat (6) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        @(posedge clk); #1;
        v = '0; or_s = 1'b0;
        repeat (5) begin
          #2 check("stall_in_ready", {31'd0, rdy[0]}, 32'd0);
          @(posedge clk); #1;
        end
        or_s = 1'b1;
      end
      send(0, bp_a[i], bp_b[i], bp_sub[i], bp_exp[i], 1'b0);
    end
    idle();
    repeat (12) @(posedge clk);

    send(0, 19'h11111, 19'h00001, 1'b0, 20'h11112, 1'b0);
    send(0, 19'h22222, 19'h00002, 1'b0, 20'h22224, 1'b0);
    send(0, 19'h33333, 19'h00003, 1'b1, 20'hB3330, 1'b0);
    @(posedge clk); #1;
    v = '0; or_s = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_out_valid", {31'd0, ov[0]}, 32'd1);
    #2 rst = 1'b1;
    q0.delete();
    #1;
    check("async_reset_out_valid", {31'd0, ov[0]}, 32'd0);
    check("async_reset_sum", {12'd0, s0}, 32'd0);
    check("async_reset_in_ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; or_s = 1'b1;
    issue(0, 19'h00010, 19'h00020, 1'b0, 20'h00030, 1'b1);
    idle();
    repeat (8) @(posedge clk);

    send(1, 19'h40000, 19'h40000, 1'b0, 20'h80000, 1'b1);
    send(2, 19'h003FF, 19'h00001, 1'b0, 20'h00400, 1'b1);
    idle();
    repeat (12) @(posedge clk);
    #1;
    check("drained_dut0", q0.size(), 32'd0);
    check("drained_dut1", q1.size(), 32'd0);
    check("drained_dut2", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
